// File: rtl/spine_ingress_scheduler_pkg.sv
// Shared NoC definitions for the spine ingress scheduler: FSM encoding and flit field positions.
package spine_ingress_scheduler_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  localparam int DEST_MSB = 15;
  localparam int DEST_LSB = 10;

  function automatic logic [DEST_MSB-DEST_LSB:0] flit_dest(input logic [15:0] flit);
    return flit[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/spine_ingress_scheduler_rr_pick4.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);

  logic [3:0] rot;
  logic [1:0] off;

  always_comb begin
    // rot[k] is the request at position (ptr + k) mod 4
    case (ptr)
      2'd0:    rot = req;
      2'd1:    rot = {req[0],   req[3:1]};
      2'd2:    rot = {req[1:0], req[3:2]};
      default: rot = {req[2:0], req[3]};
    endcase
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    idx   = ptr + off;
    found = |req;
  end

endmodule

// File: rtl/spine_ingress_scheduler.sv
// Round-robin burst scheduler merging four spine flit streams into one registered output.
module spine_ingress_scheduler
  import spine_ingress_scheduler_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      arb_enable,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DWIDTH-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                grant_id,
  output logic                      busy
);

  // Handshake: a flit moves on any cycle where its valid and ready are both 1;
  // valid never depends on ready, and ready is only raised for the current owner.

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  sched_state_e      state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [DWIDTH-1:0] lane [NUM_REQ];
  logic [1:0]        pick_idx;
  logic              pick_found;
  logic              slot_free;
  logic              owner_valid;
  logic              accept;
  logic              last_flit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = req_data[i*DWIDTH +: DWIDTH];
  end

  rr_pick4 u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    owner_valid = req_valid[owner_q];
    accept      = (state_q == GRANT) && slot_free && owner_valid;
    last_flit   = (burst_cnt_q == LAST_BEAT);

    req_ready = '0;
    if (state_q == GRANT && slot_free) req_ready[owner_q] = 1'b1;

    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      out_data_d  = lane[owner_q];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == IDLE) begin
      if (arb_enable && pick_found) begin
        owner_d     = pick_idx;
        burst_cnt_d = 4'd0;
        state_d     = GRANT;
      end
    end else begin
      if (accept) burst_cnt_d = burst_cnt_q + 4'd1;
      // A stalled output keeps the grant even if the owner's valid drops
      if ((accept && last_flit) || (slot_free && !owner_valid) || !arb_enable) begin
        state_d  = IDLE;
        rr_ptr_d = owner_q + 2'd1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      burst_cnt_q <= 4'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_id  = owner_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_spine_ingress_scheduler.sv
// Directed bench for spine_ingress_scheduler: burst, fairness, backpressure, release and reset cases.
module tb_spine_ingress_scheduler;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        arb_enable;
  logic [63:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic        busy;

  logic [15:0] lane [4];
  int          cnt [4];
  int          lim [4];
  logic [15:0] base [4];
  logic [15:0] exp_q [$];
  int          n_pass = 0;
  int          n_total = 0;

  bit          tbl_ov   [10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
  bit          tbl_busy [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  logic [1:0]  tbl_gid  [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [15:0] tbl_fair [5]  = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h1004};

  always #5 ACLK = ~ACLK;

  assign req_data = {lane[3], lane[2], lane[1], lane[0]};

  spine_ingress_scheduler #(
    .DWIDTH    (16),
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .arb_enable (arb_enable),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (cnt[i] < lim[i]);
      lane[i]      = base[i] + 16'(cnt[i]);
    end
  endtask

  task automatic clear_spines();
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      lim[i]  = 0;
      base[i] = 16'h0;
    end
  endtask

  task automatic spine(input int i, input logic [15:0] b, input int n);
    cnt[i]  = 0;
    lim[i]  = n;
    base[i] = b;
  endtask

  task automatic start_scenario();
    drive();
    #1;
  endtask

  // Scoreboard the output handshake, advance spines that handshook, set next-cycle controls
  task automatic end_cycle(input logic nxt_ready, input logic nxt_en);
    logic [3:0]  fire;
    logic [15:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_flit", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_flit", 32'(out_data), 32'(e));
      end
    end
    fire = req_valid & req_ready;
    @(posedge ACLK);
    #1;
    for (int i = 0; i < 4; i++) if (fire[i]) cnt[i]++;
    out_ready  = nxt_ready;
    arb_enable = nxt_en;
    drive();
    #1;
  endtask

  initial begin
    ARESETn    = 1'b0;
    arb_enable = 1'b1;
    out_ready  = 1'b1;
    clear_spines();
    drive();
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_grant_id",  32'(grant_id),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    #1;

    // Fairness: all four spines requesting, pointer starts at 0
    clear_spines();
    spine(0, 16'h1000, 8);
    spine(1, 16'h2000, 4);
    spine(2, 16'h3000, 4);
    spine(3, 16'h4000, 4);
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < 4; k++) exp_q.push_back(tbl_fair[g] + 16'(k));
    start_scenario();
    chk("fair_idle_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 27; c++) begin
      if (c % 5 == 0 && c <= 20) chk("fair_arb_idle", 32'(busy), 32'd0);
      if (c % 5 == 1 && c <= 21) chk("fair_gid", 32'(grant_id), 32'(tbl_gid[c / 5]));
      end_cycle(1'b1, 1'b1);
    end
    chk("fair_drain", 32'(exp_q.size()), 32'd0);

    // Single requester streaming six flits
    clear_spines();
    spine(2, 16'hA000, 6);
    for (int k = 0; k < 6; k++) exp_q.push_back(16'hA000 + 16'(k));
    start_scenario();
    for (int c = 0; c < 10; c++) begin
      chk("single_out_valid", 32'(out_valid), 32'(tbl_ov[c]));
      chk("single_busy", 32'(busy), 32'(tbl_busy[c]));
      if (tbl_busy[c]) chk("single_gid", 32'(grant_id), 32'd2);
      end_cycle(1'b1, 1'b1);
    end
    chk("single_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure: downstream stalls for three cycles mid-burst
    clear_spines();
    spine(3, 16'h5000, 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h5000 + 16'(k));
    start_scenario();
    for (int c = 0; c < 10; c++) begin
      if (c >= 3 && c <= 5) begin
        chk("bp_ready_low",   32'(req_ready), 32'd0);
        chk("bp_hold_valid",  32'(out_valid), 32'd1);
        chk("bp_hold_data",   32'(out_data),  32'h5001);
        chk("bp_keep_grant",  32'(busy),      32'd1);
      end
      if (c == 6) chk("bp_resume_ready", 32'(req_ready), 32'b1000);
      end_cycle(!((c + 1) >= 3 && (c + 1) <= 5), 1'b1);
    end
    chk("bp_drain", 32'(exp_q.size()), 32'd0);

    // Owner drops valid after two flits while spine 1 waits
    clear_spines();
    spine(0, 16'h6000, 2);
    spine(1, 16'h7000, 2);
    exp_q.push_back(16'h6000);
    exp_q.push_back(16'h6001);
    exp_q.push_back(16'h7000);
    exp_q.push_back(16'h7001);
    start_scenario();
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        chk("drop_busy_c3", 32'(busy), 32'd1);
        chk("drop_gid_c3",  32'(grant_id), 32'd0);
      end
      if (c == 4) begin
        chk("drop_idle_c4", 32'(busy), 32'd0);
        chk("drop_gid_hold", 32'(grant_id), 32'd0);
      end
      if (c == 5) begin
        chk("drop_busy_c5", 32'(busy), 32'd1);
        chk("drop_gid_c5",  32'(grant_id), 32'd1);
      end
      end_cycle(1'b1, 1'b1);
    end
    chk("drop_drain", 32'(exp_q.size()), 32'd0);

    // arb_enable low for cycles 2..5 of a burst
    clear_spines();
    spine(2, 16'h8000, 4);
    spine(3, 16'h9000, 2);
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h9000);
    exp_q.push_back(16'h9001);
    exp_q.push_back(16'h8002);
    exp_q.push_back(16'h8003);
    start_scenario();
    for (int c = 0; c < 16; c++) begin
      if (c == 2) begin
        chk("en_last_ready", 32'(req_ready), 32'b0100);
        chk("en_last_busy",  32'(busy), 32'd1);
      end
      if (c == 3) begin
        chk("en_out_valid", 32'(out_valid), 32'd1);
        chk("en_out_data",  32'(out_data),  32'h8001);
      end
      if (c >= 3 && c <= 6) chk("en_no_grant", 32'(busy), 32'd0);
      if (c == 7) begin
        chk("en_regrant_busy", 32'(busy), 32'd1);
        chk("en_regrant_gid",  32'(grant_id), 32'd3);
      end
      end_cycle(1'b1, !((c + 1) >= 2 && (c + 1) <= 5));
    end
    chk("en_drain", 32'(exp_q.size()), 32'd0);

    // Reset pulse mid-burst; C000 is discarded and arbitration restarts at spine 0
    clear_spines();
    spine(1, 16'hB000, 4);
    spine(3, 16'hC000, 4);
    start_scenario();
    end_cycle(1'b1, 1'b1);
    end_cycle(1'b1, 1'b1);
    chk("mid_out_valid", 32'(out_valid), 32'd1);
    chk("mid_gid", 32'(grant_id), 32'd3);
    ARESETn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data",  32'(out_data),  32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_grant_id",  32'(grant_id),  32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    end_cycle(1'b1, 1'b1);
    ARESETn = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(16'hB000 + 16'(k));
    for (int k = 1; k < 4; k++) exp_q.push_back(16'hC000 + 16'(k));
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        chk("post_rst_idle",  32'(busy), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
      end
      if (c == 1) chk("post_rst_gid", 32'(grant_id), 32'd1);
      if (c == 6) chk("post_rst_gid_next", 32'(grant_id), 32'd3);
      end_cycle(1'b1, 1'b1);
    end
    chk("rst_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spine_ingress_scheduler.md
SPINE_INGRESS_SCHEDULER -- requirements
Module: spine_ingress_scheduler

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, giving the flit width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of spine requesters; it is fixed at 4.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum number of consecutive flits per grant; legal range is 1..15.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- ACLK  input  1  clock; all state updates on the rising edge.
- ARESETn  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have the remaining ports as follows:
- arb_enable  input  1  1 = new grants allowed.
- req_data  input  NUM_REQ*DWIDTH  flit from spine i in bits [i*DWIDTH +: DWIDTH]; dest addr in each flit's [15:10].
- req_valid  input  NUM_REQ  per-spine flit valid.
- req_ready  output  NUM_REQ  per-spine accept.
- out_data  output  DWIDTH  registered flit toward the network interface.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- grant_id  output  2  current owner index.
- busy  output  1  1 while the FSM is in GRANT.

Function
REQ-006 A transfer on spine i SHALL occur on a cycle where req_valid[i] and req_ready[i] are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-007 The FSM SHALL have two states, IDLE and GRANT.
REQ-008 In IDLE, with arb_enable=1 and any req_valid set, the block SHALL select the first valid index found scanning from rr_ptr upward, modulo 4, then set owner to that index, burst_cnt to 0, and go to GRANT. This arbitration cycle SHALL accept no flit.
REQ-009 In IDLE, with arb_enable=0 or no req_valid set, the block SHALL stay in IDLE.
REQ-010 In GRANT, req_ready[owner] SHALL equal (!out_valid | out_ready), and every other req_ready bit SHALL be 0; in IDLE, all req_ready bits SHALL be 0.
REQ-011 On an accepted flit, out_data SHALL load req_data[owner], out_valid SHALL be 1 on the next cycle, and burst_cnt SHALL increment. Latency from accept to out_valid is 1 cycle.
REQ-012 If out_ready=1 and no flit is accepted in a cycle, out_valid SHALL go to 0 on the next cycle.
REQ-013 If out_valid=1 and out_ready=0, out_data and out_valid SHALL hold.
REQ-014 GRANT SHALL release to IDLE, with rr_ptr set to (owner+1) mod 4, when any of the following holds:
- A flit is accepted with burst_cnt = MAX_BURST-1.
- req_valid[owner]=0 while req_ready[owner]=1.
- arb_enable=0. In this case any accept occurring in the same cycle still completes.
REQ-015 When the output is stalled, a drop of req_valid[owner] SHALL NOT cause release; the grant holds until the slot frees.
REQ-016 A requester SHALL be re-granted only by a normal IDLE arbitration, so that a continuously requesting spine gets at most MAX_BURST flits per MAX_BURST+1 cycles whenever another spine is waiting.
REQ-017 Requests arriving during GRANT SHALL be ignored until the next IDLE cycle.
REQ-018 grant_id SHALL equal owner, and SHALL hold its last value while in IDLE.

Reset
REQ-019 Assertion of ARESETn=0 SHALL immediately force the following values:
- FSM to IDLE.
- rr_ptr, owner, burst_cnt and grant_id to 0.
- out_valid, busy and req_ready to 0.
- out_data to 0.
REQ-020 A reset asserted mid-burst SHALL discard the registered flit without signalling it downstream.
REQ-021 Operation SHALL restart at the first rising edge after deassertion.

Structure
REQ-022 The state encoding (IDLE=0, GRANT=1) and the dest-address field position [15:10] SHALL live in the shared NoC package.
REQ-023 The block SHALL contain one sub-module, rr_pick4, which is combinational: 4-bit request plus 2-bit pointer in, 2-bit index plus found flag out.

Verification
REQ-024 Single requester: spine 2 streams 6 flits 0xA000..0xA005 with out_ready=1 -> 0xA000..0xA003 appear on consecutive cycles, then one idle cycle, then 0xA004..0xA005; grant_id=2 throughout.
REQ-025 Fairness: all four spines valid continuously with rr_ptr=0 -> grant order is 0,1,2,3,0, and each grant carries 4 flits.
REQ-026 Backpressure: out_ready=0 for 3 cycles mid-burst -> out_data holds its value, req_ready[owner]=0, and no flit is lost or duplicated.
REQ-027 Owner drops valid after 2 flits with spine 1 waiting -> release, one IDLE cycle, then grant_id=1.
REQ-028 arb_enable=0 mid-burst -> burst ends after the current cycle and no new grant is made until arb_enable=1.
REQ-029 ARESETn pulsed low for 1 cycle mid-burst -> all outputs are 0 immediately, and arbitration restarts from spine 0.
